// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, command/response bytes, parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StData,
    StStop,
    StAck,
    StWaitIdle,
    StDone
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  // Parity bit that makes the 9-bit data+parity word odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the asynchronous PS/2 pins and flags falling edges of ps2_clk.
module ps2_sync_edge (
  input  logic clk,
  input  logic clr,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic fall_o
);

  logic [2:0] clk_sr_q;
  logic [1:0] data_sr_q;

  // Shift pin levels in; reset to idle-high so reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      clk_sr_q  <= 3'b111;
      data_sr_q <= 2'b11;
    end else begin
      clk_sr_q  <= {clk_sr_q[1:0], ps2_clk_i};
      data_sr_q <= {data_sr_q[0], ps2_data_i};
    end
  end

  assign clk_sync_o  = clk_sr_q[1];
  assign data_sync_o = data_sr_q[1];
  assign fall_o      = clk_sr_q[2] & ~clk_sr_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop,
// then sample the device ACK. Lines are only ever pulled low or released.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       send,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       tx_active,
  output logic       done,
  output logic       err
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [InhW-1:0] InhPre  = InhW'(INHIBIT_CYCLES - 2);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e   state_q;
  logic [InhW-1:0] inh_cnt_q;
  logic [ToW-1:0]  to_cnt_q;
  logic [3:0]      bit_cnt_q;
  logic [8:0]      shift_q;

  logic clk_s;
  logic data_s;
  logic fall;
  logic to_hit;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .clr        (clr),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .clk_sync_o (clk_s),
    .data_sync_o(data_s),
    .fall_o     (fall)
  );

  assign to_hit    = (to_cnt_q == ToLast);
  assign tx_active = busy;

  // Transfer FSM with registered line enables and status outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (send) begin
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            shift_q    <= {odd_parity(tx_data), tx_data};
            err        <= 1'b0;
            inh_cnt_q  <= '0;
            state_q    <= StInhibit;
          end
        end
        StInhibit: begin
          // Start bit goes low while the clock is still held, so the device sees RTS on release.
          if (inh_cnt_q == InhPre) ps2_data_oe <= 1'b1;
          if (inh_cnt_q == InhLast) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            to_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            state_q     <= StReq;
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
        end
        StReq, StData, StStop, StAck, StWaitIdle: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          // Timeout wins over any edge arriving in the same cycle.
          if (to_hit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            err         <= 1'b1;
            done        <= 1'b1;
            state_q     <= StDone;
          end else begin
            unique case (state_q)
              StReq, StData: begin
                if (fall) begin
                  ps2_data_oe <= ~shift_q[0];
                  shift_q     <= {1'b0, shift_q[8:1]};
                  bit_cnt_q   <= bit_cnt_q + 1'b1;
                  state_q     <= (bit_cnt_q == 4'd8) ? StStop : StData;
                end
              end
              StStop: begin
                if (fall) begin
                  ps2_data_oe <= 1'b0;
                  bit_cnt_q   <= bit_cnt_q + 1'b1;
                  state_q     <= StAck;
                end
              end
              StAck: begin
                if (fall) begin
                  err       <= data_s;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  state_q   <= StWaitIdle;
                end
              end
              StWaitIdle: begin
                if (clk_s && data_s) begin
                  done    <= 1'b1;
                  state_q <= StDone;
                end
              end
              default: ;
            endcase
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a simple PS/2 device model.
module tb_ps2_host_tx;

  localparam int unsigned Inhibit = 8;
  localparam int unsigned Timeout = 400;
  // Device clock half period; a full 11-clock frame must fit inside the timeout window.
  localparam int Half = 16;

  logic       clk = 1'b0;
  logic       clr;
  logic       send;
  logic [7:0] tx_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_active;
  logic       done;
  logic       err;
  logic       ps2_clk;
  logic       ps2_data;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  logic       last_err = 1'b0;
  logic [1:0] last_oe  = 2'b00;

  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(Inhibit),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .send       (send),
    .tx_data    (tx_data),
    .busy       (busy),
    .tx_active  (tx_active),
    .done       (done),
    .err        (err)
  );

  // Record every done pulse with the status seen alongside it.
  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      last_err <= err;
      last_oe  <= {ps2_clk_oe, ps2_data_oe};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_send(input logic [7:0] d);
    @(negedge clk);
    send    = 1'b1;
    tx_data = d;
    @(negedge clk);
    send    = 1'b0;
  endtask

  // Wait (bounded) for the host to release the clock after inhibit.
  task automatic wait_req(input string tag);
    int n = 0;
    while (ps2_clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, ps2_clk_oe}, 32'd0);
  endtask

  task automatic wait_done(input int base, input string tag);
    int n = 0;
    while (done_cnt == base && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, done_cnt - base, 1);
  endtask

  // Device side: read start bit at RTS, then clock out nclk pulses, sampling on each rise.
  task automatic dev_frame(input int nclk, input bit ack, output logic [10:0] bits);
    int n = 0;
    bits = '0;
    while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("dev_rts_seen", {31'd0, (ps2_clk === 1'b1 && ps2_data === 1'b0)}, 32'd1);
    bits[0] = ps2_data;
    repeat (4) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (4) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (Half) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = ps2_data;
      repeat (Half) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  initial begin
    logic [10:0] bits;
    int base;
    int n;
    int inh_len;
    int dat_len;
    bit busy_seen;

    clr     = 1'b1;
    send    = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_tx_active", {31'd0, tx_active}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    clr = 1'b0;
    repeat (3) @(negedge clk);

    // 1: 8'hED with ACK; count the inhibit window.
    base = done_cnt;
    start_send(8'hED);
    inh_len = 0;
    dat_len = 0;
    n = 0;
    while (ps2_clk_oe && n < 50) begin
      inh_len++;
      if (ps2_data_oe) dat_len++;
      @(negedge clk);
      n++;
    end
    check("t1_inhibit_len", inh_len, 8);
    check("t1_start_on_last", dat_len, 1);
    dev_frame(11, 1'b1, bits);
    check("t1_frame_ed", {21'd0, bits}, 32'h7DA);
    wait_done(base, "t1_done");
    check("t1_err", {31'd0, last_err}, 0);
    repeat (5) @(negedge clk);

    // 2: 8'h00 with ACK.
    base = done_cnt;
    start_send(8'h00);
    wait_req("t2_req");
    dev_frame(11, 1'b1, bits);
    check("t2_frame_00", {21'd0, bits}, 32'h600);
    wait_done(base, "t2_done");
    check("t2_err", {31'd0, last_err}, 0);
    repeat (5) @(negedge clk);

    // 3: no ACK from the device.
    base = done_cnt;
    start_send(8'hED);
    wait_req("t3_req");
    dev_frame(11, 1'b0, bits);
    check("t3_frame_ed", {21'd0, bits}, 32'h7DA);
    wait_done(base, "t3_done");
    check("t3_err", {31'd0, last_err}, 1);
    check("t3_oe_released", {30'd0, last_oe}, 0);
    repeat (5) @(negedge clk);

    // 4: device never clocks; timeout after exactly Timeout cycles in the clocked phase.
    start_send(8'hF4);
    wait_req("t4_req");
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout_cycles", n, 400);
    check("t4_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    check("t4_err", {31'd0, err}, 1);
    @(negedge clk);
    check("t4_busy_after", {31'd0, busy}, 0);
    repeat (5) @(negedge clk);

    // 5: a second send mid-frame is ignored.
    base = done_cnt;
    start_send(8'hED);
    wait_req("t5_req");
    fork
      dev_frame(11, 1'b1, bits);
      begin
        repeat (120) @(negedge clk);
        send    = 1'b1;
        tx_data = 8'hF4;
        @(negedge clk);
        send    = 1'b0;
      end
    join
    check("t5_frame_ed", {21'd0, bits}, 32'h7DA);
    wait_done(base, "t5_done");
    check("t5_err", {31'd0, last_err}, 0);
    base = done_cnt;
    busy_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("t5_no_second", {31'd0, busy_seen}, 0);
    check("t5_no_second_done", done_cnt - base, 0);

    // 6: clr during DATA, then a clean 8'hFF, then send with clr in the same cycle.
    start_send(8'h00);
    wait_req("t6_req");
    dev_frame(3, 1'b0, bits);
    check("t6_data_driven", {31'd0, ps2_data_oe}, 1);
    clr = 1'b1;
    @(negedge clk);
    check("t6_clr_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    check("t6_clr_busy", {31'd0, busy}, 0);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    base = done_cnt;
    start_send(8'hFF);
    wait_req("t6_req_ff");
    dev_frame(11, 1'b1, bits);
    check("t6_frame_ff", {21'd0, bits}, 32'h7FE);
    wait_done(base, "t6_done");
    check("t6_err", {31'd0, last_err}, 0);
    repeat (5) @(negedge clk);
    send    = 1'b1;
    clr     = 1'b1;
    tx_data = 8'hFF;
    @(negedge clk);
    send = 1'b0;
    clr  = 1'b0;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || ps2_clk_oe) busy_seen = 1'b1;
    end
    check("t6_clr_beats_send", {31'd0, busy_seen}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
